// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - constants and state encodings shared by the scroller, collision checker and renderer
package flappy_pkg;

  typedef enum logic [2:0] {
    QIdle   = 3'b001,
    QRun    = 3'b010,
    QFreeze = 3'b100
  } state_t;

  localparam int NUM_PIPES = 3;
  localparam int SCREEN_W  = 640;
  localparam int PIPE_W    = 80;
  localparam int GAP_H     = 100;
  localparam int BIRD_X    = 160;
  localparam int Y_MIN     = 60;
  localparam int SPACING   = 240;
  localparam int SPEED     = 2;
  localparam int SCORE_MAX = 999;

  localparam logic [23:0] LFSR_SEED = 24'hACE15A;

  // Gap top spans Y_MIN .. Y_MIN+255 from one random byte.
  function automatic logic [9:0] gap_top(input logic [7:0] r);
    return 10'(Y_MIN) + {2'b00, r};
  endfunction

  function automatic logic signed [11:0] pipe_x_init(input int i);
    return 12'(SCREEN_W + i * SPACING);
  endfunction

endpackage

// File: rtl/gap_lfsr.sv
// rtl/gap_lfsr.sv - free-running 24-bit Fibonacci LFSR supplying random gap heights
import flappy_pkg::*;

module gap_lfsr (
  input  logic        Clk,
  input  logic        reset,
  output logic [23:0] q
);

  // Taps 24,23,22,17 (1-based), shifting toward the MSB.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls and recycles three pipes, tracks the current pipe and the score
import flappy_pkg::*;

module pipe_scroller (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Frame_Tick,
  input  logic        Lose,
  output logic [9:0]  X_Edge,
  output logic [9:0]  Y_Edge,
  output logic [35:0] Pipe_X_All,
  output logic [29:0] Pipe_Y_All,
  output logic [9:0]  Score,
  output logic        Pass_Pulse,
  output logic        Running
);

  localparam logic signed [11:0] X_SPEED  = 12'(SPEED);
  localparam logic signed [11:0] X_PIPE_W = 12'(PIPE_W);
  localparam logic signed [11:0] X_BIRD   = 12'(BIRD_X);
  localparam logic signed [11:0] X_WRAP   = 12'(NUM_PIPES * SPACING);
  localparam logic signed [11:0] X_MAX    = 12'sd1023;
  localparam logic [9:0]         Y_RESET  = 10'(Y_MIN + 128);
  localparam logic [9:0]         S_MAX    = 10'(SCORE_MAX);

  state_t             state_q, state_d;
  logic signed [11:0] x_q [NUM_PIPES];
  logic signed [11:0] x_d [NUM_PIPES];
  logic [9:0]         y_q [NUM_PIPES];
  logic [9:0]         y_d [NUM_PIPES];
  logic [1:0]         cur_q, cur_d;
  logic [9:0]         score_d;
  logic               pass_d;
  logic               low_byte_used;
  logic [23:0]        lfsr;
  logic signed [11:0] cur_x;

  gap_lfsr u_gap_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .q     (lfsr)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= QIdle;
      cur_q      <= 2'd0;
      Score      <= 10'd0;
      Pass_Pulse <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= pipe_x_init(i);
        y_q[i] <= Y_RESET;
      end
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      Score      <= score_d;
      Pass_Pulse <= pass_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    score_d       = Score;
    pass_d        = 1'b0;
    low_byte_used = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end

    case (state_q)
      QIdle: begin
        if (Start) begin
          state_d = QRun;
          cur_d   = 2'd0;
          score_d = 10'd0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i] = pipe_x_init(i);
          end
          y_d[0] = gap_top(lfsr[7:0]);
          y_d[1] = gap_top(lfsr[15:8]);
          y_d[2] = gap_top(lfsr[23:16]);
        end
      end

      QRun: begin
        // Lose wins over a coincident tick so the frozen frame shows the collision position.
        if (Lose) begin
          state_d = QFreeze;
        end else if (Frame_Tick) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i] = x_q[i] - X_SPEED;
            if (x_d[i] <= -X_PIPE_W) begin
              x_d[i] = x_d[i] + X_WRAP;
              y_d[i] = low_byte_used ? gap_top(lfsr[15:8]) : gap_top(lfsr[7:0]);
              low_byte_used = 1'b1;
            end
          end
          if (x_d[cur_q] + X_PIPE_W < X_BIRD) begin
            cur_d  = (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;
            pass_d = 1'b1;
            if (Score < S_MAX) begin
              score_d = Score + 10'd1;
            end
          end
        end
      end

      QFreeze: begin
        if (Ack) begin
          state_d = QIdle;
        end
      end

      default: state_d = QIdle;
    endcase
  end

  always_comb begin
    cur_x = x_q[cur_q];
    if (cur_x < 12'sd0) begin
      X_Edge = 10'd0;
    end else if (cur_x > X_MAX) begin
      X_Edge = 10'd1023;
    end else begin
      X_Edge = cur_x[9:0];
    end
  end

  assign Y_Edge     = y_q[cur_q];
  assign Pipe_X_All = {x_q[2], x_q[1], x_q[0]};
  assign Pipe_Y_All = {y_q[2], y_q[1], y_q[0]};
  assign Running    = (state_q == QRun);

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - directed and randomized checks of pipe_scroller against a frame-level game model
module tb_pipe_scroller;

  logic        Clk = 1'b0;
  logic        reset;
  logic        Start, Ack, Frame_Tick, Lose;
  logic [9:0]  X_Edge, Y_Edge, Score;
  logic [35:0] Pipe_X_All;
  logic [29:0] Pipe_Y_All;
  logic        Pass_Pulse, Running;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 freeze; positions as plain integers.
  int          m_state;
  int          m_x [3];
  int          m_y [3];
  int          m_cur;
  int          m_score;
  bit          m_pass;
  logic [23:0] m_lfsr;

  int          pulses;
  logic [9:0]  y0;
  logic [35:0] px;

  pipe_scroller dut (
    .Clk        (Clk),
    .reset      (reset),
    .Start      (Start),
    .Ack        (Ack),
    .Frame_Tick (Frame_Tick),
    .Lose       (Lose),
    .X_Edge     (X_Edge),
    .Y_Edge     (Y_Edge),
    .Pipe_X_All (Pipe_X_All),
    .Pipe_Y_All (Pipe_Y_All),
    .Score      (Score),
    .Pass_Pulse (Pass_Pulse),
    .Running    (Running)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] lfsr_next(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 3; i++) begin
      m_x[i] = 640 + 240 * i;
      m_y[i] = 188;
    end
    m_cur   = 0;
    m_score = 0;
    m_pass  = 0;
    m_lfsr  = 24'hACE15A;
  endtask

  task automatic model_step();
    logic [23:0] nl;
    int k;
    nl     = lfsr_next(m_lfsr);
    m_pass = 0;
    case (m_state)
      0: if (Start) begin
        m_state = 1;
        for (int i = 0; i < 3; i++) m_x[i] = 640 + 240 * i;
        m_y[0]  = 60 + int'(m_lfsr[7:0]);
        m_y[1]  = 60 + int'(m_lfsr[15:8]);
        m_y[2]  = 60 + int'(m_lfsr[23:16]);
        m_score = 0;
        m_cur   = 0;
      end
      1: if (Lose) begin
        m_state = 2;
      end else if (Frame_Tick) begin
        k = 0;
        for (int i = 0; i < 3; i++) begin
          m_x[i] = m_x[i] - 2;
          if (m_x[i] <= -80) begin
            m_x[i] = m_x[i] + 720;
            m_y[i] = 60 + ((k == 0) ? int'(m_lfsr[7:0]) : int'(m_lfsr[15:8]));
            k++;
          end
        end
        if (m_x[m_cur] + 80 < 160) begin
          m_cur  = (m_cur + 1) % 3;
          m_pass = 1;
          if (m_score < 999) m_score++;
        end
      end
      default: if (Ack) m_state = 0;
    endcase
    m_lfsr = nl;
  endtask

  task automatic check_all(input string tag);
    int xe;
    xe = m_x[m_cur];
    if (xe < 0) xe = 0;
    if (xe > 1023) xe = 1023;
    chk({tag, "_x_edge"}, 36'(X_Edge), 36'(xe));
    chk({tag, "_y_edge"}, 36'(Y_Edge), 36'(m_y[m_cur]));
    chk({tag, "_pipe_x"}, Pipe_X_All, {12'(m_x[2]), 12'(m_x[1]), 12'(m_x[0])});
    chk({tag, "_pipe_y"}, 36'(Pipe_Y_All), 36'({10'(m_y[2]), 10'(m_y[1]), 10'(m_y[0])}));
    chk({tag, "_score"}, 36'(Score), 36'(m_score));
    chk({tag, "_pass"}, 36'(Pass_Pulse), 36'(m_pass));
    chk({tag, "_running"}, 36'(Running), 36'(m_state == 1));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Ack = 1'b0; Frame_Tick = 1'b0; Lose = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    cycle("idle");

    // Start with no ticks, then a second Start while running.
    Start = 1'b1;
    cycle("start");
    px = {12'd1120, 12'd880, 12'd640};
    chk("start_x_edge_640", 36'(X_Edge), 36'd640);
    chk("start_pipe_x", Pipe_X_All, px);
    chk("start_running", 36'(Running), 36'd1);
    cycle("start_again");
    Start = 1'b0;

    // Scroll to the first pass.
    Frame_Tick = 1'b1;
    for (int t = 1; t <= 280; t++) cycle("scroll");
    chk("tick280_no_pass", 36'(Pass_Pulse), 36'd0);
    cycle("tick281");
    chk("tick281_pass", 36'(Pass_Pulse), 36'd1);
    chk("tick281_score", 36'(Score), 36'd1);
    chk("tick281_x_edge", 36'(X_Edge), 36'd318);
    chk("tick281_x0", 36'(Pipe_X_All[11:0]), 36'd78);
    for (int t = 282; t <= 360; t++) cycle("scroll2");
    px = {12'd400, 12'd160, 12'd640};
    chk("tick360_recycle", Pipe_X_All, px);
    y0 = Pipe_Y_All[9:0];
    chk("tick360_y0_range", 36'(y0 >= 10'd60 && y0 <= 10'd315), 36'd1);

    // Lose with a coincident tick, frozen ticks, Ack, restart.
    Lose = 1'b1;
    cycle("lose");
    chk("lose_pipe_x", Pipe_X_All, px);
    Lose = 1'b0;
    for (int f = 0; f < 10; f++) cycle("frozen");
    Frame_Tick = 1'b0;
    Ack = 1'b1;
    cycle("ack");
    Ack = 1'b0;
    chk("ack_score_held", 36'(Score), 36'd1);
    Start = 1'b1;
    cycle("restart");
    Start = 1'b0;
    chk("restart_score", 36'(Score), 36'd0);

    // Saturation near SCORE_MAX.
    m_score = 998;
    force dut.Score = 10'd998;
    cycle("force");
    release dut.Score;
    Frame_Tick = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 410; t++) begin
      cycle("sat");
      if (Pass_Pulse) pulses++;
    end
    Frame_Tick = 1'b0;
    chk("sat_pulses", 36'(pulses), 36'd2);
    chk("sat_score", 36'(Score), 36'd999);

    // Randomized play.
    for (int n = 0; n < 1500; n++) begin
      Frame_Tick = ($urandom_range(2) == 0);
      Lose       = ($urandom_range(60) == 0);
      Ack        = ($urandom_range(15) == 0);
      Start      = ($urandom_range(15) == 0);
      cycle("rand");
    end

    // Reset at an arbitrary phase while running.
    Start = 1'b1; Lose = 1'b0; Ack = 1'b0; Frame_Tick = 1'b1;
    for (int n = 0; n < 3; n++) cycle("pre_reset");
    Start = 1'b0;
    for (int n = 0; n < int'($urandom_range(300, 50)); n++) cycle("pre_reset_run");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    px = {12'd1120, 12'd880, 12'd640};
    chk("mid_reset_pipe_x", Pipe_X_All, px);
    chk("mid_reset_pipe_y", 36'(Pipe_Y_All), 36'({10'd188, 10'd188, 10'd188}));
    chk("mid_reset_pass", 36'(Pass_Pulse), 36'd0);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 800; n++) begin
      Frame_Tick = ($urandom_range(1) == 0);
      Lose       = ($urandom_range(100) == 0);
      Ack        = ($urandom_range(10) == 0);
      Start      = ($urandom_range(10) == 0);
      cycle("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
